// File: rtl/button_debounce_select.sv
// Four-button debouncer with press/release strobes and a registered note
// selection (0 none, 1..4 single button, 7 chord) for the tone generator.
module button_debounce_select #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_n,
    output logic [3:0] pressed,
    output logic [3:0] press_pulse,
    output logic [3:0] release_pulse,
    output logic [2:0] note_code,
    output logic       note_change
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       meta_q, sync_q;
    logic [3:0]       stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    logic [3:0] pressed_q, pressed_d;
    logic [3:0] press_pulse_q, press_pulse_d;
    logic [3:0] release_pulse_q, release_pulse_d;
    logic [2:0] note_code_q, note_code_d;
    logic       note_change_q, note_change_d;

    // Any disagreement that does not persist restarts the count from zero.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Strobes compare the new level against the registered one so they line
    // up with the cycle in which pressed changes.
    assign pressed_d       = ~stable_q;
    assign press_pulse_d   = pressed_d & ~pressed_q;
    assign release_pulse_d = ~pressed_d & pressed_q;

    always_comb begin
        note_code_d = 3'd7;
        case (pressed_q)
            4'b0000: note_code_d = 3'd0;
            4'b0001: note_code_d = 3'd1;
            4'b0010: note_code_d = 3'd2;
            4'b0100: note_code_d = 3'd3;
            4'b1000: note_code_d = 3'd4;
            default: note_code_d = 3'd7;
        endcase
    end

    assign note_change_d = (note_code_d != note_code_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q          <= 4'hF;
            sync_q          <= 4'hF;
            stable_q        <= 4'hF;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            pressed_q       <= 4'h0;
            press_pulse_q   <= 4'h0;
            release_pulse_q <= 4'h0;
            note_code_q     <= 3'd0;
            note_change_q   <= 1'b0;
        end else begin
            meta_q          <= btn_n;
            sync_q          <= meta_q;
            stable_q        <= stable_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            note_code_q     <= note_code_d;
            note_change_q   <= note_change_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign note_code     = note_code_q;
    assign note_change   = note_change_q;

endmodule

// File: tb/tb_button_debounce_select.sv
// Directed bench for button_debounce_select with a 4-cycle debounce window.
module tb_button_debounce_select;

    localparam int unsigned DC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_n;
    logic [3:0] pressed, press_pulse, release_pulse;
    logic [2:0] note_code;
    logic       note_change;
    logic [15:0] obs;

    int checks   = 0;
    int failures = 0;

    button_debounce_select #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_n         (btn_n),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .note_code     (note_code),
        .note_change   (note_change)
    );

    always #5 clk = ~clk;

    // {pressed, press_pulse, release_pulse, note_code, note_change}
    assign obs = {pressed, press_pulse, release_pulse, note_code, note_change};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        btn_n = 4'h0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (obs !== 16'h0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", c, obs, 16'h0);
            end
        end
        btn_n = 4'hF;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (obs !== 16'h0) begin
                failures++;
                $display("FAIL reset_release cyc=%0d got=%h exp=%h", c, obs, 16'h0);
            end
        end
    endtask

    task automatic test_bounce_reject;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                btn_n = (c < 3) ? 4'b1101 : 4'b1111;
                tick();
                checks++;
                if (obs !== 16'h0) begin
                    failures++;
                    $display("FAIL bounce rep=%0d cyc=%0d got=%h exp=%h", r, c, obs, 16'h0);
                end
            end
        end
        btn_n = 4'hF;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (obs !== 16'h0) begin
                failures++;
                $display("FAIL bounce_settle cyc=%0d got=%h exp=%h", c, obs, 16'h0);
            end
        end
    endtask

    task automatic test_single_press;
        logic [15:0] exp;
        btn_n = 4'b1110;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (e < 6)       exp = 16'h0;
            else if (e == 6) exp = {4'b0001, 4'b0001, 4'b0000, 3'd0, 1'b0};
            else             exp = {4'b0001, 4'b0000, 4'b0000, 3'd1, (e == 7)};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL single_press edge=%0d got=%h exp=%h", e, obs, exp);
            end
        end
    endtask

    task automatic test_chord;
        logic [3:0]  btn_t [2] = '{4'b1010, 4'b1011};
        logic [3:0]  old_p [2] = '{4'b0001, 4'b0101};
        logic [3:0]  new_p [2] = '{4'b0101, 4'b0100};
        logic [2:0]  old_c [2] = '{3'd1, 3'd7};
        logic [2:0]  new_c [2] = '{3'd7, 3'd3};
        logic [15:0] exp;
        for (int ph = 0; ph < 2; ph++) begin
            btn_n = btn_t[ph];
            for (int e = 0; e < 10; e++) begin
                tick();
                if (e < 6)
                    exp = {old_p[ph], 8'h00, old_c[ph], 1'b0};
                else if (e == 6)
                    exp = {new_p[ph], new_p[ph] & ~old_p[ph], old_p[ph] & ~new_p[ph], old_c[ph], 1'b0};
                else
                    exp = {new_p[ph], 8'h00, new_c[ph], (e == 7) && (new_c[ph] != old_c[ph])};
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL chord ph=%0d edge=%0d got=%h exp=%h", ph, e, obs, exp);
                end
            end
        end
    endtask

    task automatic test_release;
        logic [3:0]  btn_t [3] = '{4'b1111, 4'b0111, 4'b1111};
        logic [3:0]  old_p [3] = '{4'b0100, 4'b0000, 4'b1000};
        logic [3:0]  new_p [3] = '{4'b0000, 4'b1000, 4'b0000};
        logic [2:0]  old_c [3] = '{3'd3, 3'd0, 3'd4};
        logic [2:0]  new_c [3] = '{3'd0, 3'd4, 3'd0};
        logic [15:0] exp;
        for (int ph = 0; ph < 3; ph++) begin
            btn_n = btn_t[ph];
            for (int e = 0; e < 10; e++) begin
                tick();
                if (e < 6)
                    exp = {old_p[ph], 8'h00, old_c[ph], 1'b0};
                else if (e == 6)
                    exp = {new_p[ph], new_p[ph] & ~old_p[ph], old_p[ph] & ~new_p[ph], old_c[ph], 1'b0};
                else
                    exp = {new_p[ph], 8'h00, new_c[ph], (e == 7) && (new_c[ph] != old_c[ph])};
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL release ph=%0d edge=%0d got=%h exp=%h", ph, e, obs, exp);
                end
            end
        end
    endtask

    task automatic test_reset_midcount;
        logic [15:0] exp;
        btn_n = 4'b1110;
        for (int e = 0; e < 4; e++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 16'h0) begin
            failures++;
            $display("FAIL midcount_assert got=%h exp=%h", obs, 16'h0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (e < 6)       exp = 16'h0;
            else if (e == 6) exp = {4'b0001, 4'b0001, 4'b0000, 3'd0, 1'b0};
            else             exp = {4'b0001, 4'b0000, 4'b0000, 3'd1, (e == 7)};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL midcount_restart edge=%0d got=%h exp=%h", e, obs, exp);
            end
        end
        btn_n = 4'hF;
        for (int e = 0; e < 10; e++) tick();
        checks++;
        if (obs !== 16'h0) begin
            failures++;
            $display("FAIL midcount_cleanup got=%h exp=%h", obs, 16'h0);
        end
    endtask

    task automatic test_simultaneous;
        logic [3:0]  btn_t [2] = '{4'b1100, 4'b1111};
        logic [3:0]  old_p [2] = '{4'b0000, 4'b0011};
        logic [3:0]  new_p [2] = '{4'b0011, 4'b0000};
        logic [2:0]  old_c [2] = '{3'd0, 3'd7};
        logic [2:0]  new_c [2] = '{3'd7, 3'd0};
        logic [15:0] exp;
        for (int ph = 0; ph < 2; ph++) begin
            btn_n = btn_t[ph];
            for (int e = 0; e < 10; e++) begin
                tick();
                if (e < 6)
                    exp = {old_p[ph], 8'h00, old_c[ph], 1'b0};
                else if (e == 6)
                    exp = {new_p[ph], new_p[ph] & ~old_p[ph], old_p[ph] & ~new_p[ph], old_c[ph], 1'b0};
                else
                    exp = {new_p[ph], 8'h00, new_c[ph], (e == 7) && (new_c[ph] != old_c[ph])};
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL simultaneous ph=%0d edge=%0d got=%h exp=%h", ph, e, obs, exp);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        btn_n = 4'hF;
        test_reset();
        test_bounce_reject();
        test_single_press();
        test_chord();
        test_release();
        test_reset_midcount();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
